node_link_stage: RTL and testbench

- Parametrised, registered link stage inserted between an upstream and a downstream node port.
- Carries NUM_CH independent channels. Each channel has flit, enable, ack and rej.
- Each channel has its own path-setup state machine and a setup timeout that self-generates a reject.
- Gives one cycle of forward latency (flit/enable) and one cycle of backward latency (ack/rej), so long inter-node links can be pipelined.

---
 rtl/noc_types_pkg.sv | 22 ++
 rtl/node_link_channel.sv | 130 +++++++++++++
 rtl/node_link_stage.sv | 43 ++++
 tb/tb_node_link_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_types_pkg.sv
// Shared NoC types: flit format, link-stage channel states and defaults.
package noc_types;

    typedef logic [7:0] flit_t;

    typedef enum logic [1:0] {
        LS_IDLE  = 2'd0,
        LS_SETUP = 2'd1,
        LS_OPEN  = 2'd2,
        LS_DRAIN = 2'd3
    } link_state_t;

    localparam int LINK_TIMEOUT_DEFAULT = 64;

    // Setup counter width: enough to hold TIMEOUT, never narrower than one bit.
    function automatic int link_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/node_link_channel.sv
// One channel of the link stage: path-setup FSM, setup timeout counter and
// the registered forward (flit/enable) and backward (ack/rej) signals.
//
// Handshake: up_enable is a level request held by upstream for the life of
// the path; up_ack is a level "path open" indication; up_rej and timeout_evt
// are single-cycle pulses. A rejected request stays blocked (DRAIN) until
// upstream drops up_enable for at least one cycle.
module node_link_channel
    import noc_types::*;
#(
    parameter int FLIT_W  = $bits(flit_t),
    parameter int TIMEOUT = LINK_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] up_flit,
    input  logic              up_enable,
    output logic              up_ack,
    output logic              up_rej,
    output logic [FLIT_W-1:0] dn_flit,
    output logic              dn_enable,
    input  logic              dn_ack,
    input  logic              dn_rej,
    output logic              timeout_evt
);

    localparam int              CNT_W    = link_cnt_width(TIMEOUT);
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    link_state_t       state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              dn_enable_n;
    logic [FLIT_W-1:0] dn_flit_n;
    logic              up_ack_n;
    logic              up_rej_n;
    logic              timeout_evt_n;

    // State, counter and all outputs are registered; reset drops everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LS_IDLE;
            cnt         <= '0;
            dn_enable   <= 1'b0;
            dn_flit     <= '0;
            up_ack      <= 1'b0;
            up_rej      <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dn_enable   <= dn_enable_n;
            dn_flit     <= dn_flit_n;
            up_ack      <= up_ack_n;
            up_rej      <= up_rej_n;
            timeout_evt <= timeout_evt_n;
        end
    end

    // Next-state and next-output decode; cancel beats reject beats ack beats timeout.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        dn_enable_n   = dn_enable;
        up_ack_n      = up_ack;
        up_rej_n      = 1'b0;
        timeout_evt_n = 1'b0;

        case (state)
            LS_IDLE: begin
                dn_enable_n = 1'b0;
                up_ack_n    = 1'b0;
                if (up_enable) begin
                    state_n     = LS_SETUP;
                    cnt_n       = '0;
                    dn_enable_n = 1'b1;
                end
            end
            LS_SETUP: begin
                if (!up_enable) begin
                    state_n     = LS_IDLE;
                    dn_enable_n = 1'b0;
                end else if (dn_rej) begin
                    state_n     = LS_DRAIN;
                    up_rej_n    = 1'b1;
                    dn_enable_n = 1'b0;
                end else if (dn_ack) begin
                    state_n  = LS_OPEN;
                    up_ack_n = 1'b1;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    state_n       = LS_DRAIN;
                    up_rej_n      = 1'b1;
                    timeout_evt_n = 1'b1;
                    dn_enable_n   = 1'b0;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LS_OPEN: begin
                if (!up_enable) begin
                    state_n     = LS_IDLE;
                    dn_enable_n = 1'b0;
                    up_ack_n    = 1'b0;
                end else if (dn_rej) begin
                    state_n     = LS_DRAIN;
                    up_ack_n    = 1'b0;
                    up_rej_n    = 1'b1;
                    dn_enable_n = 1'b0;
                end
            end
            LS_DRAIN: begin
                dn_enable_n = 1'b0;
                up_ack_n    = 1'b0;
                if (!up_enable) begin
                    state_n = LS_IDLE;
                end
            end
            default: begin
                state_n     = LS_IDLE;
                dn_enable_n = 1'b0;
                up_ack_n    = 1'b0;
            end
        endcase

        // The flit register only loads when the path is live on the next cycle.
        dn_flit_n = dn_enable_n ? up_flit : dn_flit;
    end

endmodule

// File: rtl/node_link_stage.sv
// Registered multi-channel link stage between two node ports. Each channel
// runs independently; this level only slices the flattened port vectors.
module node_link_stage
    import noc_types::*;
#(
    parameter int NUM_CH  = 4,
    parameter int FLIT_W  = $bits(flit_t),
    parameter int TIMEOUT = LINK_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*FLIT_W-1:0] up_flit,
    input  logic [NUM_CH-1:0]        up_enable,
    output logic [NUM_CH-1:0]        up_ack,
    output logic [NUM_CH-1:0]        up_rej,
    output logic [NUM_CH*FLIT_W-1:0] dn_flit,
    output logic [NUM_CH-1:0]        dn_enable,
    input  logic [NUM_CH-1:0]        dn_ack,
    input  logic [NUM_CH-1:0]        dn_rej,
    output logic [NUM_CH-1:0]        timeout_evt
);

    // One channel instance per lane, each owning its own slice of every vector.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        node_link_channel #(
            .FLIT_W  (FLIT_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .up_flit     (up_flit[c*FLIT_W +: FLIT_W]),
            .up_enable   (up_enable[c]),
            .up_ack      (up_ack[c]),
            .up_rej      (up_rej[c]),
            .dn_flit     (dn_flit[c*FLIT_W +: FLIT_W]),
            .dn_enable   (dn_enable[c]),
            .dn_ack      (dn_ack[c]),
            .dn_rej      (dn_rej[c]),
            .timeout_evt (timeout_evt[c])
        );
    end

endmodule

// File: tb/tb_node_link_stage.sv
// Bench for node_link_stage: a 4-channel instance with an 8-cycle setup
// timeout and a 1-channel instance with the timeout disabled.
module tb_node_link_stage;

    localparam int NCH = 4;
    localparam int FW  = 8;

    logic clk;
    logic rst;

    logic [NCH*FW-1:0] a_up_flit;
    logic [NCH-1:0]    a_up_enable, a_up_ack, a_up_rej, a_dn_enable, a_dn_ack, a_dn_rej, a_timeout_evt;
    logic [NCH*FW-1:0] a_dn_flit;

    logic [FW-1:0] b_up_flit, b_dn_flit;
    logic [0:0]    b_up_enable, b_up_ack, b_up_rej, b_dn_enable, b_dn_ack, b_dn_rej, b_timeout_evt;

    int total_checks;
    int passed_checks;

    node_link_stage #(.NUM_CH(NCH), .FLIT_W(FW), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst),
        .up_flit(a_up_flit), .up_enable(a_up_enable),
        .up_ack(a_up_ack), .up_rej(a_up_rej),
        .dn_flit(a_dn_flit), .dn_enable(a_dn_enable),
        .dn_ack(a_dn_ack), .dn_rej(a_dn_rej),
        .timeout_evt(a_timeout_evt)
    );

    node_link_stage #(.NUM_CH(1), .FLIT_W(FW), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .up_flit(b_up_flit), .up_enable(b_up_enable),
        .up_ack(b_up_ack), .up_rej(b_up_rej),
        .dn_flit(b_dn_flit), .dn_enable(b_dn_enable),
        .dn_ack(b_dn_ack), .dn_rej(b_dn_rej),
        .timeout_evt(b_timeout_evt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 no request, 1 waiting for answer, 2 path connected, 3 blocked after reject
    typedef struct {
        int          phase;
        int          age;
        logic        en;
        logic [7:0]  flit;
        logic        ack;
        logic        rej;
        logic        tev;
    } ch_model_t;

    ch_model_t ma [NCH];
    ch_model_t mb;

    function automatic ch_model_t model_clear();
        ch_model_t m;
        m.phase = 0; m.age = 0; m.en = 1'b0; m.flit = 8'h00;
        m.ack = 1'b0; m.rej = 1'b0; m.tev = 1'b0;
        return m;
    endfunction

    function automatic ch_model_t model_step(input ch_model_t m, input logic ue, input logic [7:0] uf,
                                             input logic da, input logic dr, input int t);
        ch_model_t n;
        n = m;
        n.rej = 1'b0;
        n.tev = 1'b0;
        if (m.phase == 0) begin
            if (ue) begin n.phase = 1; n.age = 0; end
        end else if (m.phase == 1) begin
            if (!ue)                            n.phase = 0;
            else if (dr)                        begin n.phase = 3; n.rej = 1'b1; end
            else if (da)                        n.phase = 2;
            else if (t != 0 && m.age + 1 >= t)  begin n.phase = 3; n.rej = 1'b1; n.tev = 1'b1; end
            else                                n.age = m.age + 1;
        end else if (m.phase == 2) begin
            if (!ue)      n.phase = 0;
            else if (dr)  begin n.phase = 3; n.rej = 1'b1; end
        end else begin
            if (!ue) n.phase = 0;
        end
        n.en  = (n.phase == 1) || (n.phase == 2);
        n.ack = (n.phase == 2);
        if (n.en) n.flit = uf;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) ma[c] = model_clear();
            mb = model_clear();
        end else begin
            for (int c = 0; c < NCH; c++)
                ma[c] = model_step(ma[c], a_up_enable[c], a_up_flit[c*FW +: FW], a_dn_ack[c], a_dn_rej[c], 8);
            mb = model_step(mb, b_up_enable[0], b_up_flit, b_dn_ack[0], b_dn_rej[0], 0);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passed_checks++;
    endtask

    // Every falling edge: all outputs of both instances against the model.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("a%0d_dn_enable", c), 32'(a_dn_enable[c]), 32'(ma[c].en));
            chk($sformatf("a%0d_dn_flit", c), 32'(a_dn_flit[c*FW +: FW]), 32'(ma[c].flit));
            chk($sformatf("a%0d_up_ack", c), 32'(a_up_ack[c]), 32'(ma[c].ack));
            chk($sformatf("a%0d_up_rej", c), 32'(a_up_rej[c]), 32'(ma[c].rej));
            chk($sformatf("a%0d_timeout_evt", c), 32'(a_timeout_evt[c]), 32'(ma[c].tev));
        end
        chk("b_dn_enable", 32'(b_dn_enable[0]), 32'(mb.en));
        chk("b_dn_flit", 32'(b_dn_flit), 32'(mb.flit));
        chk("b_up_ack", 32'(b_up_ack[0]), 32'(mb.ack));
        chk("b_up_rej", 32'(b_up_rej[0]), 32'(mb.rej));
        chk("b_timeout_evt", 32'(b_timeout_evt[0]), 32'(mb.tev));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int c, input logic [7:0] v);
        a_up_flit[c*FW +: FW] = v;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst         = 1'b1;
        a_up_flit   = '0; a_up_enable = '0; a_dn_ack = '0; a_dn_rej = '0;
        b_up_flit   = '0; b_up_enable = '0; b_dn_ack = '0; b_dn_rej = '0;
        repeat (2) tick();
        chk("rst_dn_enable", 32'(a_dn_enable), 32'h0);
        chk("rst_up_ack", 32'(a_up_ack), 32'h0);
        chk("rst_dn_flit", a_dn_flit, 32'h0);
        rst = 1'b0;
        tick();

        // Basic setup on ch0, plus the no-timeout instance requesting forever.
        b_up_enable = 1'b1; b_up_flit = 8'h3C;
        a_up_enable[0] = 1'b1; set_flit(0, 8'hA5);
        tick();
        chk("setup_dn_enable0", 32'(a_dn_enable[0]), 32'h1);
        chk("setup_dn_flit0", 32'(a_dn_flit[7:0]), 32'hA5);
        chk("setup_up_ack0", 32'(a_up_ack[0]), 32'h0);
        tick();
        a_dn_ack[0] = 1'b1;
        tick();
        chk("open_up_ack0", 32'(a_up_ack[0]), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            set_flit(0, 8'(i));
            tick();
            chk("open_flit0", 32'(a_dn_flit[7:0]), 32'(i));
        end
        a_dn_ack[0] = 1'b0;
        tick();
        chk("ack_drop_ignored0", 32'(a_up_ack[0]), 32'h1);

        // Reject on ch1, stale request stays blocked, then a fresh request.
        a_up_enable[1] = 1'b1; set_flit(1, 8'h11);
        tick();
        a_dn_rej[1] = 1'b1;
        tick();
        chk("rej_pulse1", 32'(a_up_rej[1]), 32'h1);
        chk("rej_dn_enable1", 32'(a_dn_enable[1]), 32'h0);
        chk("rej_up_ack1", 32'(a_up_ack[1]), 32'h0);
        a_dn_rej[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain_dn_enable1", 32'(a_dn_enable[1]), 32'h0);
        end
        a_up_enable[1] = 1'b0;
        tick();
        a_up_enable[1] = 1'b1;
        tick();
        chk("resetup_dn_enable1", 32'(a_dn_enable[1]), 32'h1);
        a_up_enable[1] = 1'b0;
        tick();

        // Timeout on ch2: reject pulse 8 cycles after entering setup.
        a_up_enable[2] = 1'b1; set_flit(2, 8'h22);
        tick();
        repeat (7) tick();
        chk("pre_timeout_rej2", 32'(a_up_rej[2]), 32'h0);
        chk("pre_timeout_en2", 32'(a_dn_enable[2]), 32'h1);
        tick();
        chk("timeout_rej2", 32'(a_up_rej[2]), 32'h1);
        chk("timeout_evt2", 32'(a_timeout_evt[2]), 32'h1);
        chk("timeout_en2", 32'(a_dn_enable[2]), 32'h0);
        tick();
        chk("timeout_pulse_end2", 32'(a_timeout_evt[2]), 32'h0);
        a_up_enable[2] = 1'b0;
        tick();

        // Ack and reject together on ch3: reject wins.
        a_up_enable[3] = 1'b1; set_flit(3, 8'h33);
        tick();
        a_dn_ack[3] = 1'b1; a_dn_rej[3] = 1'b1;
        tick();
        chk("both_rej3", 32'(a_up_rej[3]), 32'h1);
        chk("both_ack3", 32'(a_up_ack[3]), 32'h0);
        a_dn_ack[3] = 1'b0; a_dn_rej[3] = 1'b0; a_up_enable[3] = 1'b0;
        tick();

        // Ack on the exact timeout edge on ch2: ack wins.
        a_up_enable[2] = 1'b1;
        tick();
        repeat (7) tick();
        a_dn_ack[2] = 1'b1;
        tick();
        chk("ack_on_to_ack2", 32'(a_up_ack[2]), 32'h1);
        chk("ack_on_to_evt2", 32'(a_timeout_evt[2]), 32'h0);
        chk("ack_on_to_rej2", 32'(a_up_rej[2]), 32'h0);
        a_dn_ack[2] = 1'b0; a_up_enable[2] = 1'b0;
        tick();

        // Independence: ch0 open, ch1 timing out, ch3 rejected, ch2 idle.
        a_up_enable[1] = 1'b1; a_up_enable[3] = 1'b1;
        set_flit(0, 8'h40);
        tick();
        a_dn_rej[3] = 1'b1; set_flit(0, 8'h41);
        tick();
        chk("indep_rej", 32'(a_up_rej), 32'b1000);
        a_dn_rej[3] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_flit(0, 8'(8'h42 + i));
            tick();
        end
        chk("indep_timeout_evt", 32'(a_timeout_evt), 32'b0010);
        chk("indep_up_rej", 32'(a_up_rej), 32'b0010);
        chk("indep_up_ack", 32'(a_up_ack), 32'b0001);
        chk("indep_dn_enable", 32'(a_dn_enable), 32'b0001);
        chk("indep_flit0", 32'(a_dn_flit[7:0]), 32'h48);

        // Asynchronous reset while ch0 is open.
        a_up_enable[1] = 1'b0; a_up_enable[3] = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dn_enable0", 32'(a_dn_enable[0]), 32'h0);
        chk("arst_up_ack0", 32'(a_up_ack[0]), 32'h0);
        chk("arst_dn_flit0", 32'(a_dn_flit[7:0]), 32'h0);
        chk("arst_up_rej", 32'(a_up_rej), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("post_arst_setup0", 32'(a_dn_enable[0]), 32'h1);
        chk("post_arst_ack0", 32'(a_up_ack[0]), 32'h0);

        // Timeout disabled: still requesting after 1000 cycles, never rejected.
        repeat (1000) tick();
        chk("no_timeout_en_b", 32'(b_dn_enable[0]), 32'h1);
        chk("no_timeout_flit_b", 32'(b_dn_flit), 32'h3C);
        chk("no_timeout_rej_b", 32'(b_up_rej[0]), 32'h0);

        a_up_enable = '0; b_up_enable = '0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
